// File: rtl/pc_stack_unit.sv
// Program-counter unit with increment, absolute jump, signed relative branch,
// and a LIFO hardware call/return stack with sticky overflow/underflow flags.
module pc_stack_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int OFF_WIDTH   = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               res_n,
    input  logic                               stall,
    input  logic                               wr_en,
    input  logic                               branch,
    input  logic                               call,
    input  logic                               ret,
    input  logic [PC_WIDTH-1:0]                counteradress,
    input  logic [OFF_WIDTH-1:0]               offset,
    input  logic                               clr_err,
    output logic [PC_WIDTH-1:0]                pc,
    output logic                               stack_empty,
    output logic                               stack_full,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               ovf_err,
    output logic                               unf_err
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] r_pc;
    logic [DW-1:0]       r_depth;
    logic                r_ovf;
    logic                r_unf;
    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_off_ext;
    logic [PC_WIDTH-1:0] w_pc_branch;
    logic [AW-1:0]       w_top_idx;
    logic [AW-1:0]       w_push_idx;
    logic [PC_WIDTH-1:0] w_top;
    logic                w_empty;
    logic                w_full;

    logic [PC_WIDTH-1:0] w_pc_next;
    logic [DW-1:0]       w_depth_next;
    logic                w_ovf_next;
    logic                w_unf_next;
    logic                w_push;

    // Sign-extend the offset to the PC width, or truncate it when wider.
    generate
        if (OFF_WIDTH >= PC_WIDTH) begin : g_off_trunc
            assign w_off_ext = offset[PC_WIDTH-1:0];
        end else begin : g_off_sext
            assign w_off_ext = {{(PC_WIDTH-OFF_WIDTH){offset[OFF_WIDTH-1]}}, offset};
        end
    endgenerate

    assign w_pc_inc    = r_pc + PC_WIDTH'(1);
    assign w_pc_branch = r_pc + w_off_ext;
    assign w_empty     = (r_depth == '0);
    assign w_full      = (r_depth == DEPTH_MAX);

    // The registered depth doubles as the stack pointer: next free slot.
    assign w_push_idx = AW'(r_depth);
    assign w_top_idx  = AW'(r_depth - DW'(1));
    assign w_top      = r_stack[w_top_idx];

    always_comb begin
        w_pc_next    = r_pc;
        w_depth_next = r_depth;
        w_ovf_next   = r_ovf;
        w_unf_next   = r_unf;
        w_push       = 1'b0;
        if (!stall) begin
            if (clr_err) begin
                w_ovf_next = 1'b0;
                w_unf_next = 1'b0;
            end
            if (ret) begin
                if (!w_empty) begin
                    w_pc_next    = w_top;
                    w_depth_next = r_depth - DW'(1);
                end else begin
                    w_pc_next  = w_pc_inc;
                    w_unf_next = 1'b1;
                end
            end else if (call) begin
                if (!w_full) begin
                    w_push       = 1'b1;
                    w_pc_next    = counteradress;
                    w_depth_next = r_depth + DW'(1);
                end else begin
                    w_pc_next  = w_pc_inc;
                    w_ovf_next = 1'b1;
                end
            end else if (wr_en) begin
                w_pc_next = counteradress;
            end else if (branch) begin
                w_pc_next = w_pc_branch;
            end else begin
                w_pc_next = w_pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_pc    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_depth <= w_depth_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    // Entry contents carry no reset; only the depth decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign pc          = r_pc;
    assign depth       = r_depth;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign ovf_err     = r_ovf;
    assign unf_err     = r_unf;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboarded bench for pc_stack_unit: directed scenarios plus random strobes
// checked against a queue-based behavioural model.
module tb_pc_stack_unit;

    localparam int PW = 8;
    localparam int OW = 8;
    localparam int SD = 4;
    localparam int DW = $clog2(SD + 1);

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic          stall = 1'b0, wr_en = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0, clr_err = 1'b0;
    logic [PW-1:0] counteradress = '0;
    logic [OW-1:0] offset = '0;
    logic [PW-1:0] pc;
    logic          stack_empty, stack_full, ovf_err, unf_err;
    logic [DW-1:0] depth;

    pc_stack_unit #(.PC_WIDTH(PW), .OFF_WIDTH(OW), .STACK_DEPTH(SD)) dut (
        .clk(clk), .res_n(res_n), .stall(stall), .wr_en(wr_en), .branch(branch),
        .call(call), .ret(ret), .counteradress(counteradress), .offset(offset),
        .clr_err(clr_err), .pc(pc), .stack_empty(stack_empty), .stack_full(stack_full),
        .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int depth;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    int   m_pc = 0;
    int   m_stack[$];
    bit   m_ovf = 0;
    bit   m_unf = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step(input bit s, input bit r, input bit c, input bit w,
                              input bit b, input bit clr, input int a, input int o);
        int so;
        if (s) return;
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (r) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin
                m_pc = (m_pc + 1) % 256;
                m_unf = 1;
            end
        end else if (c) begin
            if (m_stack.size() < SD) begin
                m_stack.push_back((m_pc + 1) % 256);
                m_pc = a;
            end else begin
                m_pc = (m_pc + 1) % 256;
                m_ovf = 1;
            end
        end else if (w) begin
            m_pc = a;
        end else if (b) begin
            so = (o >= 128) ? o - 256 : o;
            m_pc = (m_pc + so) & 255;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    // One clock of stimulus: drive on negedge, queue the expectation, wait past the edge.
    task automatic step(input bit s, input bit r, input bit c, input bit w,
                        input bit b, input bit clr, input int a, input int o);
        exp_t e;
        @(negedge clk);
        stall = s; ret = r; call = c; wr_en = w; branch = b; clr_err = clr;
        counteradress = PW'(a);
        offset = OW'(o);
        model_step(s, r, c, w, b, clr, a, o);
        e.pc = m_pc;
        e.depth = m_stack.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: after each active edge, pop one expectation and compare all outputs.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== PW'(e.pc) || depth !== DW'(e.depth) || ovf_err !== e.ovf ||
                unf_err !== e.unf || stack_empty !== (e.depth == 0) ||
                stack_full !== (e.depth == SD)) begin
                errors++;
                $display("FAIL state got pc=%0d depth=%0d empty=%0b full=%0b ovf=%0b unf=%0b expected pc=%0d depth=%0d ovf=%0b unf=%0b",
                         pc, depth, stack_empty, stack_full, ovf_err, unf_err,
                         e.pc, e.depth, e.ovf, e.unf);
            end
            $display("txn t=%0t pc=%0d depth=%0d ovf=%0b unf=%0b", $time, pc, depth, ovf_err, unf_err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held across the first posedge, released just after an edge.
        #17;
        res_n = 1'b1;
        model_reset();
        #1;
        check("reset_pc", int'(pc), 0);
        check("reset_empty", int'(stack_empty), 1);
        check("reset_full", int'(stack_full), 0);
        check("reset_errs", int'({ovf_err, unf_err}), 0);

        // Free run, then jump and wrap.
        idle(2);
        step(0, 0, 0, 1, 0, 0, 32, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 0, 255, 0);
        idle(2);

        // Branches backward and forward across the wrap.
        step(0, 0, 0, 1, 0, 0, 40, 0);
        step(0, 0, 0, 0, 1, 0, 0, 8'hF8);
        step(0, 0, 0, 1, 0, 0, 250, 0);
        step(0, 0, 0, 0, 1, 0, 0, 10);

        // Nested call/return.
        step(0, 0, 0, 1, 0, 0, 5, 0);
        step(0, 0, 1, 0, 0, 0, 8'h10, 0);
        idle(1);
        step(0, 0, 1, 0, 0, 0, 8'h20, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Overflow, underflow, clear; call at 255 pushes 0.
        step(0, 0, 0, 1, 0, 0, 255, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 100 + i, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        // Error set wins over simultaneous clear.
        step(0, 1, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);

        // Stall freezes everything, then ret beats wr_en.
        step(0, 0, 1, 0, 0, 0, 60, 0);
        step(1, 1, 1, 1, 1, 1, 9, 3);
        step(1, 1, 1, 1, 0, 0, 9, 0);
        step(0, 1, 0, 1, 0, 0, 9, 0);

        // Random mix with stack activity.
        for (int i = 0; i < 400; i++) begin
            int sel;
            bit s, r, c, w, b, clr;
            sel = $urandom_range(99);
            s   = (sel < 10);
            r   = ($urandom_range(99) < 20);
            c   = ($urandom_range(99) < 25);
            w   = ($urandom_range(99) < 15);
            b   = ($urandom_range(99) < 25);
            clr = ($urandom_range(99) < 8);
            step(s, r, c, w, b, clr, $urandom_range(255), $urandom_range(255));
        end

        // Asynchronous reset during a stall with entries stacked.
        step(0, 0, 1, 0, 0, 0, 77, 0);
        step(0, 0, 1, 0, 0, 0, 88, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        stall = 1'b1;
        #1;
        res_n = 1'b0;
        #1;
        check("async_rst_pc", int'(pc), 0);
        check("async_rst_depth", int'(depth), 0);
        check("async_rst_empty", int'(stack_empty), 1);
        check("async_rst_errs", int'({ovf_err, unf_err}), 0);
        @(posedge clk);
        #2;
        stall = 1'b0; ret = 1'b0; call = 1'b0; wr_en = 1'b0; branch = 1'b0; clr_err = 1'b0;
        res_n = 1'b1;
        model_reset();
        // A ret right after reset underflows, so the old stack is truly gone.
        idle(2);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit for the Jac1-8 core: the next generation of the flat program counter, with the same increment and absolute-load behaviour plus signed relative branches, a hardware call/return stack, a stall input, and stack status/error flags. It sits between the instruction decoder, which drives the control strobes, and the instruction memory address port, which consumes `pc`. All state is registered; `pc` changes only on the rising clock edge.

## Interface
Parameters:
- `PC_WIDTH`, 8, width of the program counter and of every stored return address
- `OFF_WIDTH`, 8, width of the signed two's-complement branch offset
- `STACK_DEPTH`, 4, number of return-address entries (≥2, power of two not required)

Ports:
- `clk`  in  1  core clock, rising edge active
- `res_n`  in  1  reset, asynchronous, active-low
- `stall`  in  1  hold all state this cycle
- `wr_en`  in  1  absolute jump to `counteradress`
- `branch`  in  1  relative branch by `offset`
- `call`  in  1  push return address, jump to `counteradress`
- `ret`  in  1  pop return address into `pc`
- `counteradress`  in  PC_WIDTH  jump/call target
- `offset`  in  OFF_WIDTH  signed branch offset, relative to current `pc`
- `clr_err`  in  1  clear sticky error flags
- `pc`  out  PC_WIDTH  current program counter (registered)
- `stack_empty`  out  1  stack holds 0 entries
- `stack_full`  out  1  stack holds STACK_DEPTH entries
- `depth`  out  $clog2(STACK_DEPTH+1)  current entry count
- `ovf_err`  out  1  sticky: call attempted while full
- `unf_err`  out  1  sticky: ret attempted while empty

## Operation
- Reset (`res_n`=0, asynchronous): `pc`=0, depth=0, `stack_empty`=1, `stack_full`=0, `ovf_err`=`unf_err`=0. Stack entry contents are not reset and are don't-care.
- Per-edge action, evaluated in priority order. Exactly one action executes:
  1. `stall`: nothing changes, including the error flags. `clr_err` is ignored while stalled.
  2. `ret`: if depth>0, `pc` ← top entry and depth−1. If depth=0, `pc` ← `pc`+1 and `unf_err` ← 1.
  3. `call`: if depth<STACK_DEPTH, push `pc`+1, `pc` ← `counteradress`, and depth+1. If full, `pc` ← `pc`+1, `ovf_err` ← 1, and the stack is unchanged.
  4. `wr_en`: `pc` ← `counteradress`.
  5. `branch`: `pc` ← `pc` + sign-extended `offset`.
  6. Otherwise: `pc` ← `pc`+1.
- Arithmetic is modulo 2^PC_WIDTH. `pc`+1 at all-ones wraps to 0, and the branch sum is truncated. The pushed return address also wraps: a call at 255 pushes 0.
- If `OFF_WIDTH` > `PC_WIDTH`, the offset is truncated to `PC_WIDTH` after sign extension.
- The stack is LIFO, with a stack pointer and one register array. Push and pop never occur in the same cycle, by priority.
- `clr_err` (unstalled) clears both sticky flags. If an error occurs in the same cycle, the set wins.
- `stack_empty`, `stack_full` and `depth` are derived from the registered depth only; they never depend on the current-cycle strobes.

## Timing
- An action takes effect on the edge where its strobe is sampled, so the new `pc` is visible one cycle later. There is no combinational path from any input to `pc`.
- After `res_n` rises, `pc` reads 0 until the first edge, then counts 1, 2, …
- A `wr_en` or `call` sampled at edge N puts the target on `pc` after edge N. Increments resume at edge N+1.
- `ret` after `call` with no intervening stack operation restores exactly call-site `pc`+1.
- Flags update on the same edge as the causing action.
- Asserting reset mid-sequence immediately zeroes `pc` and depth and discards all stacked returns.

## Test plan
- Reset then free run: hold `res_n`=0 for 10 ns, then release. `pc` = 0, 1, 2, 3 on successive cycles, and `stack_empty`=1.
- Jump and wrap: at `pc`=2 pulse `wr_en` with `counteradress`=32, giving `pc`=32 then 33. Then jump to 255: `pc`=255, then 0.
- Branch: at `pc`=40 with `offset`=−8 (0xF8) gives `pc`=32. At `pc`=250 with `offset`=+10 gives `pc`=4.
- Nested call/return: call 0x10 at `pc`=5, then call 0x20 at `pc`=0x11, giving depth=2. The first `ret` gives `pc`=0x12 and the second gives `pc`=6, with depth 0.
- Overflow/underflow: perform 4 calls, giving `stack_full`=1. A 5th call gives `pc`+1 and `ovf_err`=1 with depth still 4. Do 4 rets, then a 5th: `unf_err`=1 and `pc` increments. Then `clr_err` clears both flags.
- Stall and priority: hold `stall` with `call`,`ret`,`wr_en` asserted, and `pc` and depth must stay frozen. Release `stall` with `ret`+`wr_en` both asserted at depth 1: the pop wins. Assert reset mid-stall: `pc`=0 and depth=0 immediately, without waiting for a clock edge.
